// File: rtl/neuron_mac_sequencer.sv
// Single-neuron perceptron sequencer: walks a synchronous weight ROM
// (bias at 0, weights at 1..N_INPUTS), pairs each weight with one streamed
// sample, accumulates in Q16.16 and emits a saturated Q8.8 activation.
module neuron_mac_sequencer #(
   parameter int N_INPUTS = 10,
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 16,
   parameter int ACC_W    = 40
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_dout,
   input  logic [DATA_W-1:0] x_data,
   input  logic              x_valid,
   output logic              x_ready,
   output logic [DATA_W-1:0] y_value,
   output logic              y_fire,
   output logic              y_valid,
   input  logic              y_ready
);

   localparam int IDX_W = $clog2(N_INPUTS + 1);

   // Output clamp bounds, expressed at accumulator width after the >>>8.
   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_MAC, S_DONE} state_t;

   state_t                   state_q, state_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [ADDR_W-1:0]        rom_addr_q, rom_addr_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;

   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    prod_ext;
   logic signed [ACC_W-1:0]    bias_ext;
   logic signed [ACC_W-1:0]    acc_sh;
   logic [DATA_W-1:0]          sat_val;

   // Datapath: full-width product and Q8.8 -> Q16.16 bias alignment.
   always_comb begin
      prod     = $signed(rom_dout) * $signed(x_data);
      prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
      bias_ext = {{(ACC_W-DATA_W){rom_dout[DATA_W-1]}}, rom_dout} << 8;
   end

   // Q16.16 accumulator back to Q8.8, clamped to the representable range.
   always_comb begin
      acc_sh = acc_q >>> 8;
      if (acc_sh > SAT_MAX)
         sat_val = {1'b0, {(DATA_W-1){1'b1}}};
      else if (acc_sh < SAT_MIN)
         sat_val = {1'b1, {(DATA_W-1){1'b0}}};
      else
         sat_val = acc_sh[DATA_W-1:0];
   end

   // State and datapath registers; reset drops any partial evaluation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         rom_addr_q <= '0;
         acc_q      <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         rom_addr_q <= rom_addr_d;
         acc_q      <= acc_d;
      end
   end

   // Next-state logic: FETCH covers ROM latency, MAC stalls on x_valid.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      rom_addr_d = rom_addr_q;
      acc_d      = acc_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               idx_d      = '0;
               rom_addr_d = '0;
               acc_d      = '0;
               state_d    = S_FETCH;
            end
         end
         S_FETCH: state_d = S_MAC;
         S_MAC: begin
            if (idx_q == '0) begin
               acc_d      = bias_ext;
               idx_d      = IDX_W'(1);
               rom_addr_d = ADDR_W'(1);
               state_d    = S_FETCH;
            end else if (x_valid) begin
               acc_d = acc_q + prod_ext;
               if (idx_q == IDX_W'(N_INPUTS)) begin
                  state_d = S_DONE;
               end else begin
                  idx_d      = idx_q + IDX_W'(1);
                  rom_addr_d = ADDR_W'(idx_q) + ADDR_W'(1);
                  state_d    = S_FETCH;
               end
            end
         end
         S_DONE: if (y_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from state; result fields read zero outside DONE.
   always_comb begin
      busy     = (state_q != S_IDLE);
      rom_addr = rom_addr_q;
      x_ready  = (state_q == S_MAC) && (idx_q != '0);
      y_valid  = (state_q == S_DONE);
      y_value  = y_valid ? sat_val : '0;
      y_fire   = y_valid & ~acc_q[ACC_W-1];
   end

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Bench for neuron_mac_sequencer: behavioural ROM, scoreboard of expected
// {fire, value} pairs pushed at start and popped when y_valid appears.
module tb_neuron_mac_sequencer;

   localparam int N = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        busy;
   logic [15:0] rom_addr;
   logic [15:0] rom_dout;
   logic [15:0] x_data;
   logic        x_valid;
   logic        x_ready;
   logic [15:0] y_value;
   logic        y_fire;
   logic        y_valid;
   logic        y_ready;

   logic [15:0] rom [0:N];
   logic [16:0] sb_q [$];
   int n_chk  = 0;
   int n_pass = 0;

   neuron_mac_sequencer #(.N_INPUTS(N), .DATA_W(16), .ADDR_W(16), .ACC_W(40)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy),
      .rom_addr(rom_addr), .rom_dout(rom_dout),
      .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
      .y_value(y_value), .y_fire(y_fire), .y_valid(y_valid), .y_ready(y_ready)
   );

   always #5 clk = ~clk;

   // Synchronous ROM, one cycle read latency.
   always @(posedge clk)
      rom_dout <= (rom_addr <= 16'(N)) ? rom[int'(rom_addr)] : 16'hDEAD;

   // Starts one evaluation and runs until y_valid (left pending in DONE).
   // x_valid is low for cycles [st_lo, st_lo+st_len); cycle c is the edge
   // count since the start edge at which the state is sampled.
   task automatic drive_eval(input logic [15:0] xd, input int st_lo, input int st_len,
                             output int arrival, output bit stall_addr_ok);
      int cnt;
      stall_addr_ok = 1'b1;
      arrival = -1;
      @(negedge clk);
      start = 1'b1; x_data = xd; x_valid = 1'b1;
      @(posedge clk);
      cnt = 0;
      @(negedge clk);
      start = 1'b0;
      while (cnt < 300) begin
         if (y_valid) begin
            arrival = cnt + 1;
            break;
         end
         x_valid = !((cnt + 1) >= st_lo && (cnt + 1) < st_lo + st_len);
         if (!x_valid && rom_addr != 16'd5) stall_addr_ok = 1'b0;
         @(posedge clk);
         cnt++;
         @(negedge clk);
      end
      x_valid = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; x_data = '0; x_valid = 1'b0; y_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_chk++; if (rom_addr !== 16'd0) $display("FAIL reset_rom_addr got=%h exp=0", rom_addr); else n_pass++;
      n_chk++; if (x_ready !== 1'b0) $display("FAIL reset_x_ready got=%b exp=0", x_ready); else n_pass++;
      n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
      n_chk++; if (y_valid !== 1'b0) $display("FAIL reset_y_valid got=%b exp=0", y_valid); else n_pass++;
      n_chk++; if (y_value !== 16'd0) $display("FAIL reset_y_value got=%h exp=0", y_value); else n_pass++;
      n_chk++; if (y_fire !== 1'b0) $display("FAIL reset_y_fire got=%b exp=0", y_fire); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Plain evaluation with constant input; checks result and arrival cycle.
   task automatic test_eval(input string nm, input logic [15:0] xd,
                            input logic [15:0] ev, input logic ef);
      int arr; bit ok; logic [16:0] e;
      sb_q.push_back({ef, ev});
      drive_eval(xd, 0, 0, arr, ok);
      n_chk++; if (arr !== 23) $display("FAIL %s_latency got=%0d exp=23", nm, arr); else n_pass++;
      e = sb_q.pop_front();
      n_chk++; if (y_value !== e[15:0]) $display("FAIL %s_value got=%h exp=%h", nm, y_value, e[15:0]); else n_pass++;
      n_chk++; if (y_fire !== e[16]) $display("FAIL %s_fire got=%b exp=%b", nm, y_fire, e[16]); else n_pass++;
   endtask

   task automatic test_stall;
      int arr; bit ok; logic [16:0] e;
      sb_q.push_back({1'b1, 16'h3700});
      drive_eval(16'h0100, 12, 3, arr, ok);
      n_chk++; if (arr !== 26) $display("FAIL stall_latency got=%0d exp=26", arr); else n_pass++;
      n_chk++; if (ok !== 1'b1) $display("FAIL stall_rom_addr_hold got=%b exp=1", ok); else n_pass++;
      e = sb_q.pop_front();
      n_chk++; if (y_value !== e[15:0]) $display("FAIL stall_value got=%h exp=%h", y_value, e[15:0]); else n_pass++;
      n_chk++; if (y_fire !== e[16]) $display("FAIL stall_fire got=%b exp=%b", y_fire, e[16]); else n_pass++;
   endtask

   task automatic test_hold;
      int arr; bit ok; int bad; logic [16:0] e;
      y_ready = 1'b0;
      sb_q.push_back({1'b1, 16'h3700});
      drive_eval(16'h0100, 0, 0, arr, ok);
      e = sb_q.pop_front();
      n_chk++; if (y_value !== e[15:0]) $display("FAIL hold_value got=%h exp=%h", y_value, e[15:0]); else n_pass++;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         start = (i == 4);
         @(posedge clk);
         @(negedge clk);
         if (y_valid !== 1'b1 || y_value !== e[15:0] || y_fire !== e[16]) bad++;
      end
      start = 1'b0;
      n_chk++; if (bad !== 0) $display("FAIL hold_stable got=%0d unstable cycles exp=0", bad); else n_pass++;
      y_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_chk++; if (busy !== 1'b0) $display("FAIL hold_release_idle got=%b exp=0", busy); else n_pass++;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_chk++; if (busy !== 1'b0) $display("FAIL hold_start_ignored got=%b exp=0", busy); else n_pass++;
      test_eval("hold_next", 16'h0100, 16'h3700, 1'b1);
   endtask

   task automatic test_mid_reset;
      int cnt; int vseen;
      @(negedge clk);
      start = 1'b1; x_data = 16'h0100; x_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      cnt = 0;
      while (!(x_ready && rom_addr == 16'd4) && cnt < 100) begin
         @(posedge clk); @(negedge clk); cnt++;
      end
      n_chk++; if (cnt >= 100) $display("FAIL midrst_reach_idx4 got=timeout exp=reached"); else n_pass++;
      rst = 1'b1;
      #1;
      n_chk++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else n_pass++;
      n_chk++; if (rom_addr !== 16'd0) $display("FAIL midrst_rom_addr got=%h exp=0", rom_addr); else n_pass++;
      n_chk++; if (x_ready !== 1'b0) $display("FAIL midrst_x_ready got=%b exp=0", x_ready); else n_pass++;
      n_chk++; if ({y_valid, y_fire, y_value} !== 18'd0) $display("FAIL midrst_y_outputs got=%b/%b/%h exp=0/0/0000", y_valid, y_fire, y_value); else n_pass++;
      vseen = 0;
      repeat (2) begin @(posedge clk); @(negedge clk); if (y_valid) vseen++; end
      rst = 1'b0;
      repeat (30) begin @(posedge clk); @(negedge clk); if (y_valid || busy) vseen++; end
      n_chk++; if (vseen !== 0) $display("FAIL midrst_no_result got=%0d active cycles exp=0", vseen); else n_pass++;
      test_eval("midrst_next", 16'h0100, 16'h3700, 1'b1);
   endtask

   // Result accepted immediately; next start issued the following cycle.
   task automatic test_back_to_back;
      test_eval("b2b_a", 16'h0100, 16'h3700, 1'b1);
      test_eval("b2b_b", 16'h0080, 16'h1B80, 1'b1);
      test_eval("b2b_c", 16'hFF00, 16'hC900, 1'b0);
   endtask

   initial begin
      rom[0] = 16'h0000;
      for (int k = 1; k <= N; k++) rom[k] = 16'(k * 256);
      test_reset();
      test_eval("pos", 16'h0100, 16'h3700, 1'b1);
      test_eval("neg", 16'hFF00, 16'hC900, 1'b0);
      test_eval("sat", 16'h7FFF, 16'h7FFF, 1'b1);
      test_stall();
      test_hold();
      test_mid_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
